// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral endpoint: oversamples SCLK/SS/MOSI in the clk domain and
// exchanges up to DEPTH words per frame, MSB first.
module spi_peripheral #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       SS,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [WORD_W-1:0]          tx_data [0:DEPTH-1],
  output logic [WORD_W-1:0]          rx_data [0:DEPTH-1],
  output logic                       rx_valid,
  output logic [$clog2(DEPTH+1)-1:0] words_rcvd,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic sclk_p1, sclk_p2, sclk_p3;
  logic ss_p1, ss_p2, ss_p3;
  logic mosi_p1, mosi_p2;
  logic vld_p1, vld_p2;
  logic armed;

  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_idx;
  logic [IDX_W-1:0]  word_sel;
  logic [WORD_W-2:0] rx_shift;
  logic [WORD_W-2:0] tx_shift;
  logic [WORD_W-1:0] rx_word;
  logic              seen_rise;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Synchroniser stages p1/p2 plus history p3; vld_pN marks pin-derived samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_p1 <= 1'b0; sclk_p2 <= 1'b0; sclk_p3 <= 1'b0;
      ss_p1   <= 1'b1; ss_p2   <= 1'b1; ss_p3   <= 1'b1;
      mosi_p1 <= 1'b0; mosi_p2 <= 1'b0;
      vld_p1  <= 1'b0; vld_p2  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sclk_p1 <= SCLK;  sclk_p2 <= sclk_p1; sclk_p3 <= sclk_p2;
      ss_p1   <= SS;    ss_p2   <= ss_p1;   ss_p3   <= ss_p2;
      mosi_p1 <= MOSI;  mosi_p2 <= mosi_p1;
      vld_p1  <= 1'b1;  vld_p2  <= vld_p1;
      // A frame may only start once SS has genuinely been seen high after reset
      if (vld_p2 && ss_p2) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_p2 & ~sclk_p3;
  assign sclk_fall = ~sclk_p2 & sclk_p3;
  assign ss_fall   = ~ss_p2 & ss_p3 & armed;
  assign ss_rise   = ss_p2 & ~ss_p3;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state == ACTIVE);
  assign words_rcvd = word_idx;
  assign word_sel   = word_idx[IDX_W-1:0];
  assign rx_word    = {rx_shift, mosi_p2};

  // Frame datapath: acts on the synchronised strobes, one event per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MISO       <= 1'b0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      word_idx   <= '0;
      bit_cnt    <= '0;
      seen_rise  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rx_data[i] <= '0;
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE && ss_fall) begin
        bit_cnt   <= '0;
        word_idx  <= '0;
        overflow  <= 1'b0;
        seen_rise <= 1'b0;
        tx_shift  <= tx_data[0][WORD_W-2:0];
        MISO      <= tx_data[0][WORD_W-1];
      end else if (state == ACTIVE && ss_rise) begin
        frame_done <= 1'b1;
        MISO       <= 1'b0;
      end else if (state == ACTIVE && sclk_rise) begin
        seen_rise <= 1'b1;
        rx_shift  <= rx_word[WORD_W-2:0];
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (word_idx < DEPTH_C) begin
            rx_data[word_sel] <= rx_word;
            rx_valid          <= 1'b1;
            word_idx          <= word_idx + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == ACTIVE && sclk_fall) begin
        if (word_idx >= DEPTH_C) begin
          MISO <= 1'b0;
        end else if (bit_cnt != '0) begin
          MISO     <= tx_shift[WORD_W-2];
          tx_shift <= tx_shift << 1;
        end else if (seen_rise) begin
          tx_shift <= tx_data[word_sel][WORD_W-2:0];
          MISO     <= tx_data[word_sel][WORD_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: acts as a mode-0 SPI controller and checks both
// directions against a word-level model of the frame.
module tb_spi_peripheral;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst_n, SCLK, SS, MOSI, MISO;
  logic [W-1:0] tx_data [0:D-1];
  logic [W-1:0] rx_data [0:D-1];
  logic         rx_valid, frame_done, overflow, busy;
  logic [2:0]   words_rcvd;

  always #5 clk = ~clk;

  spi_peripheral #(.WORD_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .words_rcvd(words_rcvd), .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;
  int nvld = 0, nfd = 0;
  logic [W-1:0] exp_rx [0:D-1];
  logic [W-1:0] ctl_tx [0:7];

  always @(negedge clk) begin
    if (rx_valid)   nvld++;
    if (frame_done) nfd++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One SCLK period: MOSI set in the low phase, MISO sampled at the rise
  task automatic clock_bit(input logic b, output logic m);
    MOSI = b;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b1;
    m = MISO;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < D; k++)
      check($sformatf("%s_rx%0d", tag, k), rx_data[k], exp_rx[k]);
  endtask

  task automatic spi_frame(input int nbits);
    int v0, f0, nfull, nexp;
    logic [W-1:0] word, want;
    logic m;
    v0 = nvld; f0 = nfd; word = '0;
    SS = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      clock_bit(ctl_tx[i / W][W - 1 - (i % W)], m);
      word = {word[W-2:0], m};
      if (i % W == W - 1) begin
        want = (i / W < D) ? tx_data[i / W] : '0;
        check($sformatf("ctl_rx_w%0d", i / W), word, want);
      end
    end
    repeat (6) @(negedge clk);
    SS = 1'b1;
    repeat (8) @(negedge clk);
    nfull = nbits / W;
    nexp  = (nfull < D) ? nfull : D;
    for (int k = 0; k < nexp; k++) exp_rx[k] = ctl_tx[k];
    check_outputs("frame");
    check("words_rcvd", words_rcvd, nexp);
    check("overflow", overflow, (nfull > D) ? 1 : 0);
    check("rx_valid_cnt", nvld - v0, nexp);
    check("frame_done_cnt", nfd - f0, 1);
    check("miso_after", MISO, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    logic m;
    int v0, nb;
    logic miso_or, busy_or;
    rst_n = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    for (int k = 0; k < D; k++) begin tx_data[k] = '0; exp_rx[k] = '0; end
    for (int k = 0; k < 8; k++) ctl_tx[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_rcvd, 0);
    check_outputs("rst");

    // Full 4-word frame
    tx_data[0] = 8'hA1; tx_data[1] = 8'hB2; tx_data[2] = 8'hC3; tx_data[3] = 8'hD4;
    ctl_tx[0] = 8'hFA; ctl_tx[1] = 8'hFB; ctl_tx[2] = 8'hFC; ctl_tx[3] = 8'hFE;
    spi_frame(32);

    // Single word; words 1..3 keep their previous contents
    tx_data[0] = 8'h5A; ctl_tx[0] = 8'h3C;
    spi_frame(8);

    // Abort five bits into word 1
    ctl_tx[0] = 8'h77; ctl_tx[1] = 8'h99;
    spi_frame(13);

    // Overflow: five words into a four-word buffer
    for (int k = 0; k < 5; k++) ctl_tx[k] = W'($urandom);
    for (int k = 0; k < D; k++) tx_data[k] = W'($urandom);
    spi_frame(40);

    // Reset during word 2 with SS held low throughout
    for (int k = 0; k < 4; k++) ctl_tx[k] = W'($urandom);
    SS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 19; i++) clock_bit(ctl_tx[i / W][W - 1 - (i % W)], m);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < D; k++) exp_rx[k] = '0;
    check("mrst_miso", MISO, 0);
    check("mrst_busy", busy, 0);
    check("mrst_words", words_rcvd, 0);
    check("mrst_overflow", overflow, 0);
    check_outputs("mrst");
    rst_n = 1'b1;
    v0 = nvld;
    for (int i = 19; i < 32; i++) clock_bit(ctl_tx[i / W][W - 1 - (i % W)], m);
    repeat (6) @(negedge clk);
    check("mrst_no_valid", nvld - v0, 0);
    check("mrst_busy_post", busy, 0);
    SS = 1'b1;
    repeat (8) @(negedge clk);
    check_outputs("mrst_post");
    for (int k = 0; k < 4; k++) ctl_tx[k] = W'($urandom);
    spi_frame(32);

    // SCLK activity with SS high must be ignored
    v0 = nvld; miso_or = 1'b0; busy_or = 1'b0;
    for (int t = 0; t < 16; t++) begin
      SCLK = ~SCLK; MOSI = 1'($urandom);
      repeat (HALF) @(negedge clk);
      miso_or |= MISO; busy_or |= busy;
    end
    check("idle_no_valid", nvld - v0, 0);
    check("idle_busy", busy_or, 0);
    check("idle_miso", miso_or, 0);
    check_outputs("idle");

    // Randomised frames of arbitrary length
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 8; k++) ctl_tx[k] = W'($urandom);
      for (int k = 0; k < D; k++) tx_data[k] = W'($urandom);
      nb = $urandom_range(1, 45);
      spi_frame(nb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
